// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: record kinds, record layout and kind decode.
package z80_trace_pkg;

  localparam int TRACE_TS_W = 32;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    FETCH  = 3'd1,
    MRD    = 3'd2,
    MWR    = 3'd3,
    IORD   = 3'd4,
    IOWR   = 3'd5,
    INTACK = 3'd6
  } kind_t;

  typedef struct packed {
    kind_t                  kind;
    logic [15:0]            addr;
    logic [7:0]             data;
    logic [TRACE_TS_W-1:0]  ts;
  } trace_rec_t;

  // M1 dominates; a write strobe outranks a read strobe within one cycle.
  function automatic kind_t decode_kind(input logic m1, input logic io,
                                        input logic rd_seen, input logic wr_seen);
    if (m1)      return io ? INTACK : FETCH;
    if (wr_seen) return io ? IOWR : MWR;
    if (rd_seen) return io ? IORD : MRD;
    return NONE;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; head is read combinationally so a pushed
// record is visible on the clock after the push.
module trace_fifo
  import z80_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  trace_rec_t    push_rec,
  input  logic          pop,
  output trace_rec_t    head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  trace_rec_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same clock frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus observer: turns each completed bus cycle into a timestamped
// record and queues it for a valid/ready consumer.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            m1_n,
  input  logic            mreq_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic            rfsh_n,
  input  logic [15:0]     a,
  input  logic [7:0]      di,
  input  logic [7:0]      dout,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [2:0]      rec_kind,
  output logic [15:0]     rec_addr,
  output logic [7:0]      rec_data,
  output logic [TS_W-1:0] rec_ts,
  output logic            overflow,
  output logic [7:0]      drop_cnt,
  output logic [LW-1:0]   level
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [TS_W-1:0] ts_cnt_reg;
  logic [TS_W-1:0] ts_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_reg;
  logic        m1_reg, io_reg, rd_seen_reg, wr_seen_reg;
  logic        overflow_reg;
  logic [7:0]  drop_cnt_reg;

  logic        strobe, start, push, pop, full, empty;
  kind_t       kind;
  trace_rec_t  push_rec, head;

  // Refresh drives MREQ low with RFSH low and must never look like a cycle.
  assign strobe = (!mreq_n && rfsh_n) || !iorq_n;
  assign kind   = decode_kind(m1_reg, io_reg, rd_seen_reg, wr_seen_reg);

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: if (strobe && en) begin
        start      = 1'b1;
        state_next = ACTIVE;
      end
      ACTIVE: if (!strobe) state_next = COMMIT;
      COMMIT: begin
        push       = (kind != NONE);
        start      = strobe && en;
        state_next = (strobe && en) ? ACTIVE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ts_cnt_reg  <= '0;
      ts_reg      <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      m1_reg      <= 1'b0;
      io_reg      <= 1'b0;
      rd_seen_reg <= 1'b0;
      wr_seen_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
      if (start) begin
        addr_reg    <= a;
        ts_reg      <= ts_cnt_reg;
        m1_reg      <= !m1_n;
        io_reg      <= !iorq_n;
        data_reg    <= '0;
        rd_seen_reg <= 1'b0;
        wr_seen_reg <= 1'b0;
      end else if (state_reg == ACTIVE) begin
        rd_seen_reg <= rd_seen_reg | !rd_n;
        wr_seen_reg <= wr_seen_reg | !wr_n;
        if (!rd_n) data_reg <= di;
        if (!wr_n) data_reg <= dout;
      end
    end
  end

  assign push_rec = '{kind: kind, addr: addr_reg, data: data_reg,
                      ts: TRACE_TS_W'(ts_reg)};
  assign pop      = rec_valid && rec_ready;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (push && full && !pop) begin
      overflow_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  // Head fields are masked while empty so stale RAM contents never leak out.
  assign rec_valid = !empty;
  assign rec_kind  = rec_valid ? head.kind : NONE;
  assign rec_addr  = rec_valid ? head.addr : '0;
  assign rec_data  = rec_valid ? head.data : '0;
  assign rec_ts    = rec_valid ? head.ts[TS_W-1:0] : '0;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule
